// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared constants, width helpers and the stage-register
// type used by pipelined_adder. Operand fields are sized to MAX_W; the adder
// only uses the low WIDTH bits and the rest stay at zero.
package pipelined_adder_pkg;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] word_t;

   // One pipeline stage: valid, the low sum slices finished so far, carry out
   // of the slice just added, signed overflow (meaningful in the last stage),
   // and the operand words still waiting for their upper slices.
   typedef struct packed {
      logic  v;
      word_t sum;
      logic  c;
      logic  ovf;
      word_t a;
      word_t b;
   } stage_t;

   function automatic int slice_w(input int width, input int stages);
      return width / stages;
   endfunction

   // Largest two's-complement value of the given width, zero-extended.
   function automatic word_t signed_max(input int width);
      word_t r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

   // Most negative two's-complement value of the given width, zero-extended.
   function automatic word_t signed_min(input int width);
      word_t r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i == width - 1) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: SW-bit ripple chain of fulladder cells. c_msb_in is the carry
// entering the top bit, used by the caller for signed-overflow detection.
module adder_slice #(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic [SW-1:0] b,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout,
   output logic          c_msb_in
);

   // Each bit keeps its own carry nets so the chain is a set of distinct wires.
   for (genvar i = 0; i < SW; i++) begin : g_bit
      logic ci;
      logic co;
      if (i == 0) begin : g_lsb
         assign ci = cin;
      end else begin : g_upper
         assign ci = g_bit[i-1].co;
      end
      fulladder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (ci),
         .sum  (sum[i]),
         .cout (co)
      );
   end

   assign cout     = g_bit[SW-1].co;
   assign c_msb_in = g_bit[SW-1].ci;

endmodule

// File: rtl/fulladder.sv
// fulladder: one-bit full adder, the building block of every adder slice.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor whose carry chain is cut into
// STAGES registered slices. Optional build macro PIPELINED_ADDER_SAT_EN makes
// the result saturate on signed overflow instead of wrapping.
//
// Handshake: a beat moves across a boundary only in a cycle where the sender
// shows valid and the receiver shows ready; in_ready and out_valid never
// depend on in_valid, and a presented result holds still until taken.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SLW  = slice_w(WIDTH, STAGES);
   localparam int LAST = STAGES - 1;

   if (WIDTH % STAGES != 0) begin : g_chk_div
      $error("pipelined_adder: WIDTH must be divisible by STAGES");
   end
   if (WIDTH < 2 || WIDTH > MAX_W) begin : g_chk_width
      $error("pipelined_adder: WIDTH out of supported range");
   end

   stage_t             st_q [STAGES];
   stage_t             st_d [STAGES];
   logic [STAGES-1:0]  load;
   logic               unused_ok;

   // Walk back from the consumer: a stage loads when empty or when its
   // contents move on, so bubbles collapse even while the output stalls.
   always_comb begin
      logic nxt;
      nxt  = out_ready;
      load = '0;
      for (int k = LAST; k >= 0; k--) begin
         load[k] = !st_q[k].v || nxt;
         nxt     = load[k];
      end
   end

   assign in_ready = load[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      word_t            src_a;
      word_t            src_b;
      word_t            prev_sum;
      word_t            new_sum;
      logic             src_v;
      logic             sci;
      logic [SLW-1:0]   sa;
      logic [SLW-1:0]   sb;
      logic [SLW-1:0]   ss;
      logic             sco;
      logic             smsb;

      if (k == 0) begin : g_first
         assign src_v    = in_valid;
         assign src_a    = word_t'(a);
         assign src_b    = word_t'(sub ? ~b : b);
         assign sci      = sub ? 1'b1 : cin;
         assign prev_sum = '0;
      end else begin : g_next
         assign src_v    = st_q[k-1].v;
         assign src_a    = st_q[k-1].a;
         assign src_b    = st_q[k-1].b;
         assign sci      = st_q[k-1].c;
         assign prev_sum = st_q[k-1].sum;
      end

      assign sa = src_a[k*SLW +: SLW];
      assign sb = src_b[k*SLW +: SLW];

      adder_slice #(.SW(SLW)) u_slice (
         .a        (sa),
         .b        (sb),
         .cin      (sci),
         .sum      (ss),
         .cout     (sco),
         .c_msb_in (smsb)
      );

      // Merge this slice into the running sum; the last slice may clamp it.
      always_comb begin
         new_sum = prev_sum;
         new_sum[k*SLW +: SLW] = ss;
`ifdef PIPELINED_ADDER_SAT_EN
         if (k == LAST && (sco ^ smsb)) begin
            new_sum = (!sa[SLW-1] && !sb[SLW-1]) ? signed_max(WIDTH) : signed_min(WIDTH);
         end
`endif
      end

      assign st_d[k] = '{v: src_v, sum: new_sum, c: sco, ovf: sco ^ smsb,
                         a: src_a, b: src_b};
   end

   // Stage registers: cleared by reset, otherwise refreshed only when allowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) st_q[k] <= st_d[k];
         end
      end
   end

   // Fold stage-register bits that no logic reads (upper padding, operands
   // left in the last stage) into one sink so they are visibly accounted for.
   always_comb begin
      unused_ok = 1'b0;
      for (int k = 0; k < STAGES; k++) unused_ok = unused_ok ^ (^st_q[k]);
   end

   assign out_valid = st_q[LAST].v;
   assign sum       = st_q[LAST].sum[WIDTH-1:0];
   assign cout      = st_q[LAST].c;
   assign ovf       = st_q[LAST].ovf;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor built from `fulladder` slices, with a valid/ready handshake on both sides. It is the next generation of the team's fixed-width ripple-carry adder. The carry chain is cut into `STAGES` registered segments, so wide operands close timing at one result per cycle. It sits between any producer/consumer pair that streams operands, such as accumulators and address generators.

## Interface
- `WIDTH`, 16: operand and result width in bits. Must be ≥ 2 and divisible by `STAGES`.
- `STAGES`, 4: number of pipeline stages. Range 1..`WIDTH`. Slice width `SW = WIDTH/STAGES`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`  in  `WIDTH`  operand A.
- `b`  in  `WIDTH`  operand B.
- `cin`  in  1  carry in; ignored when `sub`=1.
- `sub`  in  1  0 computes A+B+cin; 1 computes A−B, i.e. A+~B+1.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  `WIDTH`  result.
- `cout`  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- Stage k (0..`STAGES`−1) adds bits [k·SW +: SW] of A and B′, where B′ = `sub` ? ~B : B.
- Stage 0 carry in is `sub` ? 1 : `cin`. Stage k>0 takes the registered carry from stage k−1.
- Each stage register holds:
  - valid bit `v[k]`;
  - completed low sum slices [0 .. k·SW+SW−1];
  - carry out of the stage;
  - the not-yet-added upper slices of A and B′.
- The final stage drives `sum`, `cout` and `ovf` directly from its register. No output logic follows it.
- `ovf` = (carry into MSB) XOR (carry out of MSB). It is computed inside the last slice and registered with the result.
- Stage k loads when `!v[k]` OR stage k advances. Stage k advances when stage k+1 loads; for the last stage, when `out_ready`.
- Bubbles collapse: an empty stage always accepts from upstream, even while downstream is stalled.
- `in_ready` = `!v[0]` OR stage 0 advances. This is combinational from `out_ready` through the stall chain.
- A beat is accepted when `in_valid && in_ready`. A result is consumed when `out_valid && out_ready`.
- Results leave in acceptance order. Nothing is dropped or duplicated.
- `out_valid` = `v[STAGES−1]`.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - all `v[k]` = 0 and all data registers = 0;
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0;
  - `in_ready`=1 while `rst_n`=0 and after release.
- Reset asserted mid-stream flushes every in-flight beat. No partial result ever appears afterwards.
- Latency is `STAGES` cycles. A beat accepted at edge n is visible on `out_valid`/`sum` after edge n+`STAGES−1`, i.e. in cycle n+`STAGES`, when there are no stalls.
- Throughput is one beat per cycle while `out_ready`=1.
- Capacity is `STAGES` beats. With `out_ready` held at 0, `in_ready` falls once all stages are full.
- Consume and accept in the same cycle when full is legal. The pipeline shifts with no bubble.
- Output data is held stable while `out_valid`=1 and `out_ready`=0.
- For `STAGES`=1 the block is a single registered adder with the same handshake.

## Configuration
- `PIPELINED_ADDER_SAT_EN` defined:
  - on signed overflow, `sum` clamps to 0x7F..F when both operands are non-negative (after the B′/sub mapping) and to 0x80..0 otherwise;
  - `ovf` still reports the overflow;
  - `cout` is unchanged.
- `PIPELINED_ADDER_SAT_EN` undefined: `sum` wraps modulo 2^`WIDTH`. `ovf` and `cout` are unchanged.

## Structure
- Package `pipelined_adder_pkg`:
  - slice-width constant function `SW`;
  - signed max/min constant functions parametrised by width;
  - a stage-register struct typedef holding valid, partial sum, carry, and pending A/B′.
- Sub-module `adder_slice`: an `SW`-bit ripple chain of `fulladder` instances with ports `a`, `b`, `cin`, `sum`, `cout`, `c_msb_in`. It is instantiated once per stage via generate.
- Elaboration-time assertion that `WIDTH % STAGES == 0`.

## Test plan
All scenarios use `WIDTH`=16, `STAGES`=4.
- Reset mid-stream: 3 beats in flight, `rst_n` pulsed low → `out_valid`=0, `sum`=0, `in_ready`=1 immediately. No stale beat emerges afterwards.
- Full carry ripple: 0xFFFF + 0x0001, `cin`=0 → `sum`=0x0000, `cout`=1, `ovf`=0, exactly 4 cycles after acceptance.
- Signed overflow: 0x7FFF + 0x0001 → `ovf`=1 and `cout`=0. `sum`=0x8000 without `PIPELINED_ADDER_SAT_EN`, 0x7FFF with it.
- Subtract: 0x0005 − 0x0007, `sub`=1, `cin`=1 → `sum`=0xFFFE, `cout`=0, `ovf`=0. `cin` is ignored.
- Backpressure: 10 back-to-back random beats, `out_ready` low for cycles 5–9 → `in_ready`=0 after 4 beats are held. All 10 results match the reference model in order.
- Parameter sweep: `STAGES` ∈ {1, 2, 16} with random stimulus against a behavioural model → latency equals `STAGES` and all results match.
